// File: rtl/frame_assembler_pkg.sv
// Shared constants and state encodings for the solution frame assembler.
`timescale 1ns/1ps
package frame_assembler_pkg;

    localparam logic [7:0] START_BYTE = 8'hA5;
    localparam logic [7:0] STOP_BYTE  = 8'h5A;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_ONE  = 8'h31;
    localparam logic [7:0] ASCII_NL   = 8'h0A;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        ACK,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        START,
        DIM_M,
        DIM_N,
        PAYLOAD,
        CHECK,
        STOP
    } phase_t;

endpackage

// File: rtl/solution_byte_gen.sv
// Latches a solved grid and walks it row-major, presenting one payload byte
// at a time (bit-packed or ASCII) plus a flag marking the final payload byte.
`timescale 1ns/1ps
module solution_byte_gen
    import frame_assembler_pkg::*;
#(
    parameter int unsigned MAX_ROWS = 11,
    parameter int unsigned MAX_COLS = 11,
    localparam int unsigned CELLS = MAX_ROWS * MAX_COLS,
    localparam int unsigned MW = $clog2(MAX_ROWS + 1),
    localparam int unsigned NW = $clog2(MAX_COLS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [CELLS-1:0] solution,
    input  logic [MW-1:0]    m_raw,
    input  logic [NW-1:0]    n_raw,
    input  logic             ascii_mode,
    output logic [MW-1:0]    m_act,
    output logic [NW-1:0]    n_act,
    output logic [7:0]       pay_byte,
    output logic             pay_last,
    output logic             pay_empty
);

    localparam int unsigned CW  = $clog2(CELLS + 1);
    localparam int unsigned GIW = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam logic [MW-1:0] MAX_M = MW'(MAX_ROWS);
    localparam logic [NW-1:0] MAX_N = NW'(MAX_COLS);

    logic [CELLS-1:0] grid_q;
    logic [MW-1:0]    m_q, row_q, pk_row_nxt, m_clamp;
    logic [NW-1:0]    n_q, col_q, pk_col_nxt, n_clamp;
    logic [CW-1:0]    cell_q, total;
    logic             ascii_q, nl_q;
    logic [7:0]       pk_byte, a_byte;
    logic             pk_last, a_last;

    function automatic logic [GIW-1:0] cidx(input int r, input int c);
        return GIW'(r * int'(MAX_COLS) + c);
    endfunction

    assign m_clamp   = (m_raw > MAX_M) ? MAX_M : m_raw;
    assign n_clamp   = (n_raw > MAX_N) ? MAX_N : n_raw;
    assign total     = CW'(m_q) * CW'(n_q);
    assign m_act     = m_q;
    assign n_act     = n_q;
    assign pay_empty = (m_q == '0) || (n_q == '0);

    // Gather up to 8 active cells from the current position; also yields the
    // row/column where the following byte starts.
    always_comb begin
        int r;
        int c;
        pk_byte = '0;
        r = int'(row_q);
        c = int'(col_q);
        for (int k = 0; k < 8; k++) begin
            if (int'(cell_q) + k < int'(total)) begin
                pk_byte[k] = grid_q[cidx(r, c)];
                if (c == int'(n_q) - 1) begin
                    c = 0;
                    r = r + 1;
                end else begin
                    c = c + 1;
                end
            end
        end
        pk_row_nxt = MW'(r);
        pk_col_nxt = NW'(c);
    end

    assign pk_last = (int'(cell_q) + 8 >= int'(total));

    // ASCII byte: either the newline closing a row or the current cell character.
    always_comb begin
        a_byte = ASCII_NL;
        if (!nl_q) begin
            a_byte = grid_q[cidx(int'(row_q), int'(col_q))] ? ASCII_ONE : ASCII_ZERO;
        end
        a_last = nl_q && (row_q == m_q - 1'b1);
    end

    assign pay_byte = ascii_q ? a_byte : pk_byte;
    assign pay_last = ascii_q ? a_last : pk_last;

    // Grid capture and traversal counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grid_q  <= '0;
            m_q     <= '0;
            n_q     <= '0;
            ascii_q <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            cell_q  <= '0;
            nl_q    <= 1'b0;
        end else if (load) begin
            grid_q  <= solution;
            m_q     <= m_clamp;
            n_q     <= n_clamp;
            ascii_q <= ascii_mode;
            row_q   <= '0;
            col_q   <= '0;
            cell_q  <= '0;
            nl_q    <= 1'b0;
        end else if (step) begin
            if (ascii_q) begin
                if (nl_q) begin
                    nl_q  <= 1'b0;
                    row_q <= row_q + 1'b1;
                    col_q <= '0;
                end else if (col_q == n_q - 1'b1) begin
                    nl_q <= 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end else if (!pk_last) begin
                // Counter is held on the final byte so it never wraps.
                cell_q <= cell_q + CW'(8);
                row_q  <= pk_row_nxt;
                col_q  <= pk_col_nxt;
            end
        end
    end

endmodule

// File: rtl/frame_assembler.sv
// Frames a solved grid as A5, m, n, payload, XOR checksum, 5A and hands it to
// the UART transmitter one byte at a time using a send/busy handshake.
`timescale 1ns/1ps
module frame_assembler
    import frame_assembler_pkg::*;
#(
    parameter int unsigned MAX_ROWS = 11,
    parameter int unsigned MAX_COLS = 11,
    localparam int unsigned MW = $clog2(MAX_ROWS + 1),
    localparam int unsigned NW = $clog2(MAX_COLS + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_in,
    input  logic [MAX_ROWS*MAX_COLS-1:0] solution,
    input  logic [MW-1:0]                m,
    input  logic [NW-1:0]                n,
    input  logic                         ascii_mode,
    input  logic                         transmit_busy,
    output logic                         ready,
    output logic                         send,
    output logic [7:0]                   byte_out,
    output logic                         done
);

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [7:0]  csum_q, csum_d;
    logic [7:0]  held_q;
    logic [7:0]  cur_byte;
    logic        load, step;
    logic [MW-1:0] m_act;
    logic [NW-1:0] n_act;
    logic [7:0]  pay_byte;
    logic        pay_last, pay_empty;

    solution_byte_gen #(
        .MAX_ROWS (MAX_ROWS),
        .MAX_COLS (MAX_COLS)
    ) u_byte_gen (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .step       (step),
        .solution   (solution),
        .m_raw      (m),
        .n_raw      (n),
        .ascii_mode (ascii_mode),
        .m_act      (m_act),
        .n_act      (n_act),
        .pay_byte   (pay_byte),
        .pay_last   (pay_last),
        .pay_empty  (pay_empty)
    );

    // Byte source selected by the current frame phase.
    always_comb begin
        cur_byte = 8'h00;
        unique case (phase_q)
            START:   cur_byte = START_BYTE;
            DIM_M:   cur_byte = 8'(m_act);
            DIM_N:   cur_byte = 8'(n_act);
            PAYLOAD: cur_byte = pay_byte;
            CHECK:   cur_byte = csum_q;
            STOP:    cur_byte = STOP_BYTE;
            default: cur_byte = 8'h00;
        endcase
    end

    // Handshake FSM: issue a byte when the UART is free, then wait for it to
    // go busy before moving to the next byte.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        csum_d  = csum_q;
        send    = 1'b0;
        done    = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (valid_in) begin
                    load    = 1'b1;
                    csum_d  = 8'h00;
                    phase_d = START;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!transmit_busy) begin
                    send    = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (transmit_busy) begin
                    state_d = ISSUE;
                    unique case (phase_q)
                        START:   phase_d = DIM_M;
                        DIM_M:   phase_d = DIM_N;
                        DIM_N:   phase_d = pay_empty ? CHECK : PAYLOAD;
                        PAYLOAD: begin
                            csum_d = csum_q ^ pay_byte;
                            step   = 1'b1;
                            if (pay_last) begin
                                phase_d = CHECK;
                            end
                        end
                        CHECK:   phase_d = STOP;
                        STOP:    state_d = DONE;
                        default: state_d = IDLE;
                    endcase
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, phase, checksum and last-sent byte registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            phase_q <= START;
            csum_q  <= 8'h00;
            held_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            csum_q  <= csum_d;
            if (send) begin
                held_q <= cur_byte;
            end
        end
    end

    assign ready = (state_q == IDLE);
    // Only a send cycle exposes the new byte, so byte_out is stable between sends.
    assign byte_out = send ? cur_byte : held_q;

endmodule

// File: tb/tb_frame_assembler.sv
// Scoreboard bench for frame_assembler with a simple UART busy responder.
`timescale 1ns/1ps
module tb_frame_assembler;

    localparam int NR = 11;
    localparam int NC = 11;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_in;
    logic [120:0] solution;
    logic [3:0]   m;
    logic [3:0]   n;
    logic         ascii_mode;
    logic         transmit_busy;
    logic         ready;
    logic         send;
    logic [7:0]   byte_out;
    logic         done;

    frame_assembler #(
        .MAX_ROWS (NR),
        .MAX_COLS (NC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .solution      (solution),
        .m             (m),
        .n             (n),
        .ascii_mode    (ascii_mode),
        .transmit_busy (transmit_busy),
        .ready         (ready),
        .send          (send),
        .byte_out      (byte_out),
        .done          (done)
    );

    always #5 clk = ~clk;

    int         tests_run = 0;
    int         tests_failed = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    logic [7:0] last_sent = 8'h00;
    bit         prev_send = 1'b0;
    int         send_count = 0;
    int         done_count = 0;
    bit         saw_send = 1'b0;
    int         busy_cnt = 0;
    int         busy_len = 2;
    int         stall_at = -1;
    int         stall_len = 50;

    // Monitor: every send pops the scoreboard; between sends byte_out must hold.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (send === 1'b1) begin
                tests_run++;
                if (transmit_busy !== 1'b0 || prev_send) begin
                    tests_failed++;
                    $display("FAIL send_spacing: busy=%b prev_send=%b, required busy=0 prev_send=0",
                             transmit_busy, prev_send);
                end
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_send: got byte %02h, required no send", byte_out);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (byte_out !== mon_exp) begin
                        tests_failed++;
                        $display("FAIL frame_byte[%0d]: got %02h, required %02h",
                                 send_count, byte_out, mon_exp);
                    end
                end
                last_sent = byte_out;
                send_count++;
                saw_send = 1'b1;
            end else begin
                tests_run++;
                if (byte_out !== last_sent) begin
                    tests_failed++;
                    $display("FAIL byte_hold: got %02h, required %02h", byte_out, last_sent);
                end
            end
            if (done === 1'b1) begin
                done_count++;
                tests_run++;
                if (exp_q.size() != 0) begin
                    tests_failed++;
                    $display("FAIL done_early: %0d bytes outstanding, required 0", exp_q.size());
                end
            end
            prev_send = (send === 1'b1);
        end
    end

    // UART model: goes busy just after the edge that follows a send.
    always begin
        @(posedge clk);
        #1;
        if (rst !== 1'b1) begin
            busy_cnt = 0;
            transmit_busy = 1'b0;
            saw_send = 1'b0;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) transmit_busy = 1'b0;
        end else if (saw_send) begin
            saw_send = 1'b0;
            transmit_busy = 1'b1;
            busy_cnt = (send_count == stall_at) ? stall_len : busy_len;
        end
    end

    function automatic logic [120:0] map3(input logic [8:0] p);
        logic [120:0] g = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                g[r*NC+c] = p[r*3+c];
        return g;
    endfunction

    // Reference model of a whole frame, built from the linear cell index.
    task automatic push_model(input logic [120:0] g, input int mm, input int nn, input bit asc);
        int mc = (mm > NR) ? NR : mm;
        int nc = (nn > NC) ? NC : nn;
        logic [7:0] cs = 8'h00;
        logic [7:0] b;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(mc));
        exp_q.push_back(8'(nc));
        if (mc > 0 && nc > 0) begin
            if (asc) begin
                for (int r = 0; r < mc; r++) begin
                    for (int c = 0; c < nc; c++) begin
                        b = g[r*NC+c] ? 8'h31 : 8'h30;
                        exp_q.push_back(b);
                        cs ^= b;
                    end
                    exp_q.push_back(8'h0A);
                    cs ^= 8'h0A;
                end
            end else begin
                for (int i = 0; i < (mc * nc + 7) / 8; i++) begin
                    b = 8'h00;
                    for (int k = 0; k < 8; k++) begin
                        int j = i * 8 + k;
                        if (j < mc * nc) b[k] = g[(j / nc) * NC + (j % nc)];
                    end
                    exp_q.push_back(b);
                    cs ^= b;
                end
            end
        end
        exp_q.push_back(cs);
        exp_q.push_back(8'h5A);
    endtask

    task automatic start_frame(input logic [120:0] g, input logic [3:0] mm, input logic [3:0] nn,
                               input bit asc);
        int cyc = 0;
        while (!(ready === 1'b1 && transmit_busy === 1'b0) && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        send_count = 0;
        solution = g;
        m = mm;
        n = nn;
        ascii_mode = asc;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        // Scramble inputs: the captured copy must be what gets sent.
        for (int i = 0; i < 121; i++) solution[i] = 1'($urandom_range(0, 1));
        m = 4'($urandom_range(0, 15));
        n = 4'($urandom_range(0, 15));
        ascii_mode = ~asc;
        tests_run++;
        if (send !== 1'b1) begin
            tests_failed++;
            $display("FAIL first_send_latency: send=%b, required 1", send);
        end
    endtask

    task automatic wait_done(input int budget);
        int cyc = 0;
        while (done !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        tests_run++;
        if (done !== 1'b1) begin
            tests_failed++;
            $display("FAIL frame_done_timeout: done=%b after %0d cycles, required 1", done, cyc);
            exp_q.delete();
        end
    endtask

    task automatic finish_check(input int dc0);
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || ready !== 1'b1 || done_count != dc0 + 1) begin
            tests_failed++;
            $display("FAIL after_done: done=%b ready=%b pulses=%0d, required done=0 ready=1 pulses=1",
                     done, ready, done_count - dc0);
        end
    endtask

    task automatic wait_sends(input int target);
        int cyc = 0;
        while (send_count < target && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        tests_run++;
        if (send_count < target) begin
            tests_failed++;
            $display("FAIL send_progress: got %0d sends, required %0d", send_count, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        valid_in = 1'b0;
        solution = '0;
        m = '0;
        n = '0;
        ascii_mode = 1'b0;
        transmit_busy = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (ready !== 1'b1 || send !== 1'b0 || byte_out !== 8'h00 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_values: ready=%b send=%b byte=%02h done=%b, required 1 0 00 0",
                     ready, send, byte_out, done);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_packed_3x3();
        logic [7:0] lit [7] = '{8'hA5, 8'h03, 8'h03, 8'h77, 8'h01, 8'h76, 8'h5A};
        int dc0 = done_count;
        foreach (lit[i]) exp_q.push_back(lit[i]);
        start_frame(map3(9'b101110111), 4'd3, 4'd3, 1'b0);
        wait_done(500);
        finish_check(dc0);
    endtask

    task automatic test_ascii_3x3();
        logic [7:0] lit [17] = '{8'hA5, 8'h03, 8'h03, 8'h31, 8'h31, 8'h31, 8'h0A, 8'h30, 8'h31,
                                 8'h31, 8'h0A, 8'h31, 8'h30, 8'h31, 8'h0A, 8'h3B, 8'h5A};
        int dc0 = done_count;
        foreach (lit[i]) exp_q.push_back(lit[i]);
        start_frame(map3(9'b101110111), 4'd3, 4'd3, 1'b1);
        wait_done(1000);
        finish_check(dc0);
        tests_run++;
        if (send_count != 17) begin
            tests_failed++;
            $display("FAIL ascii_send_count: got %0d, required 17", send_count);
        end
    endtask

    task automatic test_empty();
        logic [7:0] lit [5] = '{8'hA5, 8'h00, 8'h03, 8'h00, 8'h5A};
        int dc0 = done_count;
        foreach (lit[i]) exp_q.push_back(lit[i]);
        start_frame(map3(9'b111111111), 4'd0, 4'd3, 1'b0);
        wait_done(500);
        finish_check(dc0);
    endtask

    task automatic test_busy_stall();
        logic [7:0] lit [7] = '{8'hA5, 8'h03, 8'h03, 8'h77, 8'h01, 8'h76, 8'h5A};
        int dc0 = done_count;
        foreach (lit[i]) exp_q.push_back(lit[i]);
        stall_at = 3;
        start_frame(map3(9'b101110111), 4'd3, 4'd3, 1'b0);
        wait_sends(3);
        repeat (40) @(negedge clk);
        tests_run++;
        if (send_count != 3) begin
            tests_failed++;
            $display("FAIL stall_no_send: got %0d sends, required 3", send_count);
        end
        wait_done(500);
        finish_check(dc0);
        stall_at = -1;
    endtask

    task automatic test_ignore_valid();
        logic [7:0] lit [7] = '{8'hA5, 8'h03, 8'h03, 8'h77, 8'h01, 8'h76, 8'h5A};
        int dc0 = done_count;
        foreach (lit[i]) exp_q.push_back(lit[i]);
        start_frame(map3(9'b101110111), 4'd3, 4'd3, 1'b0);
        wait_sends(2);
        solution = map3(9'b000011000);
        m = 4'd5;
        n = 4'd5;
        ascii_mode = 1'b1;
        valid_in = 1'b1;
        repeat (3) @(negedge clk);
        valid_in = 1'b0;
        wait_done(500);
        finish_check(dc0);
    endtask

    task automatic test_done_ignore();
        int sc0;
        int dc0 = done_count;
        push_model(map3(9'b010101010), 3, 3, 1'b0);
        start_frame(map3(9'b010101010), 4'd3, 4'd3, 1'b0);
        wait_done(500);
        sc0 = send_count;
        solution = map3(9'b111000111);
        m = 4'd3;
        n = 4'd3;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        repeat (20) @(negedge clk);
        tests_run++;
        if (send_count != sc0 || ready !== 1'b1 || done_count != dc0 + 1) begin
            tests_failed++;
            $display("FAIL done_cycle_valid: sends=%0d ready=%b pulses=%0d, required %0d 1 1",
                     send_count, ready, done_count - dc0, sc0);
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] lit [7] = '{8'hA5, 8'h03, 8'h03, 8'h77, 8'h01, 8'h76, 8'h5A};
        int dc0;
        push_model(map3(9'b101110111), 3, 3, 1'b1);
        start_frame(map3(9'b101110111), 4'd3, 4'd3, 1'b1);
        wait_sends(5);
        @(posedge clk);
        #2;
        rst = 1'b0;
        exp_q.delete();
        last_sent = 8'h00;
        prev_send = 1'b0;
        #1;
        tests_run++;
        if (ready !== 1'b1 || send !== 1'b0 || byte_out !== 8'h00 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset: ready=%b send=%b byte=%02h done=%b, required 1 0 00 0",
                     ready, send, byte_out, done);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        dc0 = done_count;
        foreach (lit[i]) exp_q.push_back(lit[i]);
        start_frame(map3(9'b101110111), 4'd3, 4'd3, 1'b0);
        wait_done(500);
        finish_check(dc0);
    endtask

    task automatic test_clamp_random();
        logic [120:0] g;
        logic [3:0]   mm [4] = '{4'd15, 4'd11, 4'd7, 4'd2};
        logic [3:0]   nn [4] = '{4'd13, 4'd4, 4'd5, 4'd12};
        for (int t = 0; t < 4; t++) begin
            int dc0 = done_count;
            for (int i = 0; i < 121; i++) g[i] = 1'($urandom_range(0, 1));
            push_model(g, int'(mm[t]), int'(nn[t]), 1'(t % 2));
            start_frame(g, mm[t], nn[t], 1'(t % 2));
            wait_done(3000);
            finish_check(dc0);
        end
    endtask

    initial begin
        test_reset();
        test_packed_3x3();
        test_ascii_3x3();
        test_empty();
        test_busy_stall();
        test_ignore_valid();
        test_done_ignore();
        test_mid_reset();
        busy_len = 1;
        test_clamp_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: bench did not finish, required completion");
        $fatal(1);
    end

endmodule
